// File: rtl/bb_adc_pkg.sv
// Shared definitions for the Burr-Brown serial ADC readout controller.
//   BB_WIDTH   : width of one ADC conversion result
//   state_t    : readout controller states
//   vote_state : bitwise 2-of-3 majority over three state copies
package bb_adc_pkg;

  localparam int BB_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    WAITB = 3'd2,
    WAITD = 3'd3,
    SHIFT = 3'd4,
    READY = 3'd5
  } state_t;

  function automatic state_t vote_state(input state_t a, input state_t b, input state_t c);
    return state_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/srnlce.sv
// Generic shift register with parallel load, clock enable and async clear.
// Parameters:
//   Width : register width (>= 2)
//   Left  : 1 shifts towards the MSB (SI enters bit 0), 0 shifts towards the LSB
//   TMR   : 1 keeps three copies of the register and outputs their majority
// Ports:
//   C   in  clock, rising edge
//   CE  in  clock enable; 0 holds Q
//   CLR in  asynchronous clear, active high
//   L   in  parallel load of D, has priority over shifting when CE=1
//   SI  in  serial input
//   D   in  parallel load data
//   Q   out register contents
module srnlce #(
  parameter int Width = 16,
  parameter bit Left  = 1'b1,
  parameter bit TMR   = 1'b0
) (
  input  logic             C,
  input  logic             CE,
  input  logic             CLR,
  input  logic             L,
  input  logic             SI,
  input  logic [Width-1:0] D,
  output logic [Width-1:0] Q
);

  logic [Width-1:0] q_next;

  // Next value is computed from the voted output so a single upset copy
  // is corrected on the following enabled or disabled clock edge.
  always_comb begin
    q_next = Q;
    if (CE) begin
      if (L) begin
        q_next = D;
      end else if (Left) begin
        q_next = {Q[Width-2:0], SI};
      end else begin
        q_next = {SI, Q[Width-1:1]};
      end
    end
  end

  generate
    if (TMR) begin : g_tmr
      logic [Width-1:0] q_a, q_b, q_c;

      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          q_a <= '0;
          q_b <= '0;
          q_c <= '0;
        end else begin
          q_a <= q_next;
          q_b <= q_next;
          q_c <= q_next;
        end
      end

      assign Q = (q_a & q_b) | (q_a & q_c) | (q_b & q_c);
    end else begin : g_plain
      logic [Width-1:0] q_r;

      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          q_r <= '0;
        end else begin
          q_r <= q_next;
        end
      end

      assign Q = q_r;
    end
  endgenerate

endmodule

// File: rtl/bb_adc_fsm.sv
// Burr-Brown serial ADC readout controller. A read strobe with READBB starts
// a conversion pulse, waits for the ADC busy phase (with timeout), shifts in a
// 16-bit result MSB-first and then flags DATAREADY until the strobe drops.
// Parameters:
//   TMR      : 1 triplicates state and readback registers with majority vote
//   CONV_CYC : BBCONV high time in CLK cycles (1..15)
//   BUSY_TO  : max cycles spent in WAITB waiting for ADCBUSY (1..255)
// Ports:
//   CLK       in  clock, rising edge
//   RST_B     in  asynchronous reset, active low
//   STROBE    in  VME data strobe (synchronous)
//   READBB    in  decoded read-Burr-Brown command
//   ADCBUSY   in  ADC busy, active high
//   BBSDATA   in  ADC serial data
//   BBCONV    out conversion start (registered)
//   BBSCLKEN  out serial clock enable, high during the 16 shift cycles
//   DATAREADY out result valid (registered)
//   QBB       out readback register, bit 15 = first bit received
module bb_adc_fsm
  import bb_adc_pkg::*;
#(
  parameter bit TMR      = 1'b0,
  parameter int CONV_CYC = 2,
  parameter int BUSY_TO  = 255
) (
  input  logic                CLK,
  input  logic                RST_B,
  input  logic                STROBE,
  input  logic                READBB,
  input  logic                ADCBUSY,
  input  logic                BBSDATA,
  output logic                BBCONV,
  output logic                BBSCLKEN,
  output logic                DATAREADY,
  output logic [BB_WIDTH-1:0] QBB
);

  localparam logic [3:0] CONV_LAST = 4'(CONV_CYC - 1);
  localparam logic [7:0] TO_LAST   = 8'(BUSY_TO - 1);
  localparam logic [3:0] BIT_LAST  = 4'(BB_WIDTH - 1);

  state_t     state, next_state;
  logic       start;
  logic [3:0] conv_cnt;
  logic [7:0] to_cnt;
  logic [3:0] bit_cnt;

  // State register, optionally triplicated with a majority-voted read-out.
  generate
    if (TMR) begin : g_state_tmr
      state_t st_a, st_b, st_c;

      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          st_a <= IDLE;
          st_b <= IDLE;
          st_c <= IDLE;
        end else begin
          st_a <= next_state;
          st_b <= next_state;
          st_c <= next_state;
        end
      end

      assign state = vote_state(st_a, st_b, st_c);
    end else begin : g_state
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          state <= IDLE;
        end else begin
          state <= next_state;
        end
      end
    end
  endgenerate

  // A dropped strobe aborts any active phase straight back to IDLE.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (STROBE && READBB) begin
          next_state = CONV;
          start      = 1'b1;
        end
      end
      CONV: begin
        if (!STROBE) begin
          next_state = IDLE;
        end else if (conv_cnt == CONV_LAST) begin
          next_state = WAITB;
        end
      end
      WAITB: begin
        if (!STROBE) begin
          next_state = IDLE;
        end else if (ADCBUSY) begin
          next_state = WAITD;
        end else if (to_cnt == TO_LAST) begin
          next_state = SHIFT;
        end
      end
      WAITD: begin
        if (!STROBE) begin
          next_state = IDLE;
        end else if (!ADCBUSY) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (!STROBE) begin
          next_state = IDLE;
        end else if (bit_cnt == BIT_LAST) begin
          next_state = READY;
        end
      end
      READY: begin
        if (!STROBE) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Each counter is held at zero outside its own state, so it starts from
  // zero on every entry; inside the state it saturates instead of wrapping.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      conv_cnt <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state != CONV) begin
        conv_cnt <= '0;
      end else if (conv_cnt != 4'hF) begin
        conv_cnt <= conv_cnt + 4'd1;
      end

      if (state != WAITB) begin
        to_cnt <= '0;
      end else if (to_cnt != 8'hFF) begin
        to_cnt <= to_cnt + 8'd1;
      end

      if (state != SHIFT) begin
        bit_cnt <= '0;
      end else if (bit_cnt != 4'hF) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Outputs are flops fed from next_state so they track the state register
  // exactly while never exposing a combinational path from the inputs.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      BBCONV    <= 1'b0;
      BBSCLKEN  <= 1'b0;
      DATAREADY <= 1'b0;
    end else begin
      BBCONV    <= (next_state == CONV);
      BBSCLKEN  <= (next_state == SHIFT);
      DATAREADY <= (next_state == READY);
    end
  end

  // Readback register: cleared on the start edge, shifts MSB-first in SHIFT.
  srnlce #(
    .Width(BB_WIDTH),
    .Left (1'b1),
    .TMR  (TMR)
  ) u_readback (
    .C  (CLK),
    .CE ((state == SHIFT) | start),
    .CLR(!RST_B),
    .L  (start),
    .SI (BBSDATA),
    .D  ({BB_WIDTH{1'b0}}),
    .Q  (QBB)
  );

endmodule

// File: tb/tb_bb_adc_fsm.sv
// Self-checking bench for bb_adc_fsm and the srnlce shift register.
// A transaction-level model predicts conversion pulse length, shift count,
// busy-to-shift latency and the received word from the protocol rules.
module tb_bb_adc_fsm;

  localparam int EXP_CONV = 2;
  localparam int EXP_TO   = 255;

  logic        CLK = 1'b0;
  logic        RST_B;
  logic        STROBE;
  logic        READBB;
  logic        ADCBUSY;
  logic        BBSDATA;
  logic        BBCONV;
  logic        BBSCLKEN;
  logic        DATAREADY;
  logic [15:0] QBB;

  logic       sr_ce, sr_clr, sr_l, sr_si;
  logic [7:0] sr_d, shl_q, shr_q;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  bb_adc_fsm #(
    .TMR     (1'b0),
    .CONV_CYC(EXP_CONV),
    .BUSY_TO (EXP_TO)
  ) dut (
    .CLK      (CLK),
    .RST_B    (RST_B),
    .STROBE   (STROBE),
    .READBB   (READBB),
    .ADCBUSY  (ADCBUSY),
    .BBSDATA  (BBSDATA),
    .BBCONV   (BBCONV),
    .BBSCLKEN (BBSCLKEN),
    .DATAREADY(DATAREADY),
    .QBB      (QBB)
  );

  srnlce #(.Width(8), .Left(1'b1), .TMR(1'b0)) u_shl (
    .C(CLK), .CE(sr_ce), .CLR(sr_clr), .L(sr_l), .SI(sr_si), .D(sr_d), .Q(shl_q)
  );

  srnlce #(.Width(8), .Left(1'b0), .TMR(1'b1)) u_shr (
    .C(CLK), .CE(sr_ce), .CLR(sr_clr), .L(sr_l), .SI(sr_si), .D(sr_d), .Q(shr_q)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One read transaction. The ADC model raises ADCBUSY busy_delay cycles
  // after BBCONV falls for busy_len cycles (never if stuck) and serves the
  // bits of word MSB-first while BBSCLKEN is high.
  task automatic applyStimulus(input logic [15:0] word, input int busy_delay,
                               input int busy_len, input bit stuck,
                               input bit abort_waitd, input string tag);
    int  conv_seen, sclk_seen, first_sclk, w, exp_first, bad, hold;
    bit  fell, done;
    conv_seen  = 0;
    sclk_seen  = 0;
    first_sclk = -1;
    w          = 0;
    fell       = 1'b0;
    done       = 1'b0;
    STROBE  = 1'b1;
    READBB  = 1'b1;
    ADCBUSY = 1'b0;
    BBSDATA = 1'b0;
    tick();
    checkOutput({tag, " conv_start"}, 32'(BBCONV), 32'd1);
    checkOutput({tag, " qbb_cleared"}, 32'(QBB), 32'd0);
    conv_seen = 1;
    READBB = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      tick();
      if (!fell) begin
        if (BBCONV) conv_seen++;
        else fell = 1'b1;
      end
      if (fell) w++;
      if (BBSCLKEN) begin
        sclk_seen++;
        if (first_sclk < 0) first_sclk = w;
        BBSDATA = word[16 - sclk_seen];
      end
      if (DATAREADY) begin
        done = 1'b1;
      end else if (fell) begin
        ADCBUSY = !stuck && (w >= busy_delay + 1) && (w <= busy_delay + busy_len);
        if (abort_waitd && w == busy_delay + 2) begin
          STROBE = 1'b0;
          tick();
          checkOutput({tag, " abort_conv"}, 32'(BBCONV), 32'd0);
          checkOutput({tag, " abort_sclk"}, 32'(BBSCLKEN), 32'd0);
          bad = 0;
          ADCBUSY = 1'b0;
          for (int k = 0; k < 6; k++) begin
            if (DATAREADY || BBCONV || BBSCLKEN) bad++;
            tick();
          end
          checkOutput({tag, " abort_quiet"}, 32'(bad), 32'd0);
          checkOutput({tag, " abort_qbb"}, 32'(QBB), 32'd0);
          READBB = 1'b0;
          return;
        end
      end
    end
    ADCBUSY   = 1'b0;
    exp_first = stuck ? EXP_TO + 1 : busy_delay + busy_len + 2;
    checkOutput({tag, " dataready"}, 32'(DATAREADY), 32'd1);
    checkOutput({tag, " conv_len"}, 32'(conv_seen), 32'(EXP_CONV));
    checkOutput({tag, " sclk_len"}, 32'(sclk_seen), 32'd16);
    checkOutput({tag, " shift_latency"}, 32'(first_sclk), 32'(exp_first));
    checkOutput({tag, " qbb"}, 32'(QBB), 32'(word));
    hold = int'($urandom_range(1, 6));
    bad  = 0;
    READBB = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!DATAREADY || QBB !== word || BBCONV || BBSCLKEN) bad++;
    end
    checkOutput({tag, " ready_hold"}, 32'(bad), 32'd0);
    STROBE = 1'b0;
    READBB = 1'b0;
    #1;
    checkOutput({tag, " dr_before_edge"}, 32'(DATAREADY), 32'd1);
    tick();
    checkOutput({tag, " dr_dropped"}, 32'(DATAREADY), 32'd0);
  endtask

  initial begin
    int cnt, shifted, hits;
    RST_B   = 1'b0;
    STROBE  = 1'b0;
    READBB  = 1'b0;
    ADCBUSY = 1'b0;
    BBSDATA = 1'b0;
    sr_ce   = 1'b0;
    sr_clr  = 1'b1;
    sr_l    = 1'b0;
    sr_si   = 1'b0;
    sr_d    = 8'h00;
    repeat (3) tick();
    checkOutput("reset_conv", 32'(BBCONV), 32'd0);
    checkOutput("reset_sclk", 32'(BBSCLKEN), 32'd0);
    checkOutput("reset_dr", 32'(DATAREADY), 32'd0);
    checkOutput("reset_qbb", 32'(QBB), 32'd0);
    RST_B  = 1'b1;
    sr_clr = 1'b0;
    tick();

    $display("[TB] srnlce unit checks");
    sr_ce = 1'b1; sr_l = 1'b1; sr_d = 8'h3C;
    tick();
    checkOutput("sr_load", 32'(shl_q), 32'h3C);
    sr_ce = 1'b0; sr_l = 1'b0; sr_d = 8'hFF;
    tick();
    checkOutput("sr_hold", 32'(shl_q), 32'h3C);
    sr_ce = 1'b1; sr_si = 1'b1;
    tick();
    checkOutput("sr_left", 32'(shl_q), 32'h79);
    sr_l = 1'b1; sr_d = 8'h78;
    tick();
    checkOutput("sr_load_r", 32'(shr_q), 32'h78);
    sr_l = 1'b0;
    tick();
    checkOutput("sr_right", 32'(shr_q), 32'hBC);
    sr_ce = 1'b0;
    #2 sr_clr = 1'b1;
    #1;
    checkOutput("sr_clr_l", 32'(shl_q), 32'h00);
    checkOutput("sr_clr_r", 32'(shr_q), 32'h00);
    sr_clr = 1'b0;

    $display("[TB] conversions");
    applyStimulus(16'hA5C3, 3, 10, 1'b0, 1'b0, "nominal");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 20)),
                    int'($urandom_range(1, 20)), 1'b0, 1'b0, "random");
    end
    applyStimulus(16'hFFFF, 0, 0, 1'b1, 1'b0, "timeout");
    applyStimulus(16'($urandom), 0, 0, 1'b1, 1'b0, "timeout_rnd");
    applyStimulus(16'h1234, 2, 8, 1'b0, 1'b0, "pre_abort");
    applyStimulus(16'($urandom), int'($urandom_range(0, 10)),
                  int'($urandom_range(3, 10)), 1'b0, 1'b1, "abort");
    applyStimulus(16'($urandom), 4, 5, 1'b0, 1'b0, "after_abort");

    $display("[TB] no-op strobe");
    STROBE = 1'b1;
    READBB = 1'b0;
    hits = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (BBCONV || BBSCLKEN || DATAREADY) hits++;
    end
    checkOutput("noop_quiet", 32'(hits), 32'd0);
    STROBE = 1'b0;
    tick();

    $display("[TB] reset mid-shift");
    STROBE  = 1'b1;
    READBB  = 1'b1;
    BBSDATA = 1'b1;
    cnt     = 0;
    shifted = 0;
    for (int k = 0; k < 100 && shifted < 3; k++) begin
      tick();
      cnt++;
      ADCBUSY = (cnt >= 4 && cnt < 6);
      if (BBSCLKEN) shifted++;
    end
    checkOutput("rst_reached_shift", 32'(shifted), 32'd3);
    checkOutput("rst_partial_qbb", 32'(QBB), 32'h0003);
    #3 RST_B = 1'b0;
    #1;
    checkOutput("rst_async_sclk", 32'(BBSCLKEN), 32'd0);
    checkOutput("rst_async_conv", 32'(BBCONV), 32'd0);
    checkOutput("rst_async_dr", 32'(DATAREADY), 32'd0);
    checkOutput("rst_async_qbb", 32'(QBB), 32'd0);
    STROBE  = 1'b0;
    READBB  = 1'b0;
    ADCBUSY = 1'b0;
    tick();
    #2 RST_B = 1'b1;
    tick();
    checkOutput("rst_idle_sclk", 32'(BBSCLKEN), 32'd0);
    checkOutput("rst_idle_conv", 32'(BBCONV), 32'd0);
    applyStimulus(16'h5A3C, 1, 4, 1'b0, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
